// File: rtl/fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem interface, RV32C halfword realignment.
// Presents a registered {instruction, pc, compflg, valid} bundle to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          IMEM_AW   = 10,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               select_target_pc,
   input  logic [31:0]        calculated_target_pc,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instruction,
   output logic [31:0]        pc,
   output logic               compflg,
   output logic               valid
);

   typedef enum logic [1:0] {BOOT, RUN, REFILL} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, rsp_pc;
   logic [31:0] skid, skid_pc;
   logic [15:0] hw;
   logic [31:0] hw_pc;
   logic        hw_valid, skid_valid;
   logic        rsp_vld, rsp_epoch, epoch;

   logic        pend, word_avail, consume, hw_emit, hw_full;
   logic        skid_valid_n, skid_load, w_c;
   logic [31:0] w, w_pc;
   logic        emit, e_c;
   logic [31:0] e_instr, e_pc;

   assign imem_addr = fetch_pc[IMEM_AW+1:2];

   always_comb begin
      pend       = rsp_vld & (rsp_epoch == epoch);
      w          = skid_valid ? skid : imem_rdata;
      w_pc       = skid_valid ? skid_pc : rsp_pc;
      w_c        = w[1:0] != 2'b11;
      hw_full    = hw_valid & (hw[1:0] != 2'b11);
      word_avail = skid_valid | pend;
      consume    = !stall & word_avail & !hw_full;
      hw_emit    = !stall & hw_full;
      skid_load  = pend & (skid_valid | !consume);
      skid_valid_n = (skid_valid & !consume) | skid_load;
      imem_req   = (state != BOOT) & !skid_valid_n & !hw_full;
      emit       = 1'b0;
      e_c        = 1'b0;
      e_instr    = NOP_INSTR;
      e_pc       = w_pc;
      unique case (1'b1)
         hw_emit: begin
            emit    = 1'b1;
            e_c     = 1'b1;
            e_instr = {16'h0, hw};
            e_pc    = hw_pc;
         end
         consume & hw_valid: begin
            emit    = 1'b1;
            e_instr = {w[15:0], hw};
            e_pc    = hw_pc;
         end
         consume & !hw_valid & !w_pc[1]: begin
            emit    = 1'b1;
            e_c     = w_c;
            e_instr = w_c ? {16'h0, w[15:0]} : w;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      unique case (state)
         BOOT:    state_n = RUN;
         RUN:     state_n = RUN;
         REFILL:  if (pend) state_n = RUN;
         default: state_n = BOOT;
      endcase
      if (select_target_pc) state_n = REFILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= '0;
         rsp_vld     <= 1'b0;
         rsp_epoch   <= 1'b0;
         epoch       <= 1'b0;
         skid        <= '0;
         skid_pc     <= '0;
         skid_valid  <= 1'b0;
         hw          <= '0;
         hw_pc       <= '0;
         hw_valid    <= 1'b0;
         valid       <= 1'b0;
         instruction <= NOP_INSTR;
         pc          <= '0;
         compflg     <= 1'b0;
      end else begin
         rsp_vld   <= imem_req;
         rsp_epoch <= epoch;
         if (imem_req) rsp_pc <= fetch_pc;
         if (select_target_pc) begin
            // epoch flip kills the response to this cycle's request
            epoch       <= ~epoch;
            fetch_pc    <= calculated_target_pc & ~32'd1;
            skid_valid  <= 1'b0;
            hw_valid    <= 1'b0;
            valid       <= 1'b0;
            instruction <= NOP_INSTR;
            compflg     <= 1'b0;
         end else begin
            if (imem_req) fetch_pc <= {fetch_pc[31:2], 2'b00} + 32'd4;
            skid_valid <= skid_valid_n;
            if (skid_load) begin
               skid    <= imem_rdata;
               skid_pc <= rsp_pc;
            end
            if (hw_emit) begin
               hw_valid <= 1'b0;
            end else if (consume) begin
               hw       <= w[31:16];
               hw_pc    <= {w_pc[31:2], 2'b10};
               hw_valid <= hw_valid | w_pc[1] | w_c;
            end
            if (!stall) begin
               valid       <= emit;
               instruction <= e_instr;
               compflg     <= e_c;
               if (emit) pc <= e_pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed programs, decoupled monitor.
// Expected instructions are queued by the driver and popped on each load.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        select_target_pc = 1'b0;
   logic [31:0] calculated_target_pc = '0;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        compflg;
   logic        valid;

   logic [31:0] mem [0:1023];
   exp_t        q[$];
   exp_t        last_exp;
   bit          have_last;
   bit          ld;
   int          req0_cnt;
   int          checks;
   int          failures;

   fetch_stage dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .stall               (stall),
      .select_target_pc    (select_target_pc),
      .calculated_target_pc(calculated_target_pc),
      .imem_req            (imem_req),
      .imem_addr           (imem_addr),
      .imem_rdata          (imem_rdata),
      .instruction         (instruction),
      .pc                  (pc),
      .compflg             (compflg),
      .valid               (valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (imem_req) imem_rdata <= mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req,
                  $time);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] p,
                       input logic c);
      exp_t e;
      e.instr = i;
      e.pc    = p;
      e.c     = c;
      q.push_back(e);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      stall = 1'b0;
      select_target_pc = 1'b0;
      q.delete();
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int lim);
      int n;
      n = 0;
      while (q.size() != 0 && n < lim) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_first_valid(input string name);
      repeat (2) @(posedge clk);
      #1;
      chk({name, "_early"}, {31'd0, valid}, 32'd0);
      @(posedge clk);
      #1;
      chk(name, {31'd0, valid}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_instr"}, instruction, NOP);
      chk({tag, "_pc"}, pc, 32'd0);
      chk({tag, "_compflg"}, {31'd0, compflg}, 32'd0);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      have_last = 1'b0;
      ld        = 1'b0;
      req0_cnt  = 0;
      fork
         forever begin
            @(posedge clk);
            ld = rst_n & !stall & !select_target_pc;
            if (rst_n && imem_req && imem_addr == 10'd0) req0_cnt++;
         end
         forever begin
            exp_t e;
            @(negedge clk);
            if (!rst_n) begin
               have_last = 1'b0;
            end else begin
               if (ld && valid) begin
                  if (q.size() != 0) begin
                     e = q.pop_front();
                     chk("instr", instruction, e.instr);
                     chk("pc", pc, e.pc);
                     chk("compflg", {31'd0, compflg}, {31'd0, e.c});
                     last_exp  = e;
                     have_last = 1'b1;
                  end else begin
                     have_last = 1'b0;
                  end
               end else if (ld) begin
                  have_last = 1'b0;
               end else if (valid && have_last) begin
                  chk("hold_instr", instruction, last_exp.instr);
                  chk("hold_pc", pc, last_exp.pc);
               end
               if (!valid) chk("bubble_nop", instruction, NOP);
            end
         end
      join_none

      // 1: two aligned 32-bit instructions, first valid on cycle 3
      do_reset();
      #1;
      chk_reset_vals("reset");
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      push(32'h0050_0093, 32'h0, 1'b0);
      push(32'h00A0_0113, 32'h4, 1'b0);
      release_rst();
      chk_first_valid("first_valid_c3");
      wait_drain(20);

      // 2: two c.li in one word, a single request for that word
      do_reset();
      mem[0] = 32'h4501_4505;
      mem[1] = 32'h0070_0213;
      push(32'h0000_4505, 32'h0, 1'b1);
      push(32'h0000_4501, 32'h2, 1'b1);
      push(32'h0070_0213, 32'h4, 1'b0);
      req0_cnt = 0;
      release_rst();
      wait_drain(20);
      repeat (3) @(posedge clk);
      chk("req_once", req0_cnt, 1);

      // 3: C, then 32-bit spanning the word boundary, then C, then 32-bit
      do_reset();
      mem[0] = 32'h0093_4505;
      mem[1] = 32'h4515_0050;
      mem[2] = 32'h00B0_0593;
      push(32'h0000_4505, 32'h0, 1'b1);
      push(32'h0050_0093, 32'h2, 1'b0);
      push(32'h0000_4515, 32'h6, 1'b1);
      push(32'h00B0_0593, 32'h8, 1'b0);
      release_rst();
      wait_drain(30);

      // 4: three-cycle stall mid-stream
      do_reset();
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0020_0113;
      mem[2] = 32'h4509_4505;
      mem[3] = 32'h0040_0213;
      mem[4] = 32'h0050_0293;
      push(32'h0010_0093, 32'h0, 1'b0);
      push(32'h0020_0113, 32'h4, 1'b0);
      push(32'h0000_4505, 32'h8, 1'b1);
      push(32'h0000_4509, 32'hA, 1'b1);
      push(32'h0040_0213, 32'hC, 1'b0);
      push(32'h0050_0293, 32'h10, 1'b0);
      release_rst();
      repeat (4) @(posedge clk);
      #1;
      stall = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stall = 1'b0;
      wait_drain(30);

      // 5: redirect to odd halfword with a stale word in flight
      do_reset();
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h00A0_0113;
      mem[2]  = 32'h00F0_0793;
      mem[64] = 32'h4509_0001;
      mem[65] = 32'h0030_0193;
      push(32'h0050_0093, 32'h0, 1'b0);
      push(32'h0000_4509, 32'h102, 1'b1);
      push(32'h0030_0193, 32'h104, 1'b0);
      release_rst();
      repeat (3) @(posedge clk);
      #1;
      select_target_pc     = 1'b1;
      calculated_target_pc = 32'h0000_0103;
      @(posedge clk);
      #1;
      select_target_pc = 1'b0;
      chk("redir_bubble", {31'd0, valid}, 32'd0);
      wait_drain(30);

      // 6: one-cycle reset mid-stream, refetch from RESET_PC
      do_reset();
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0020_0113;
      mem[2] = 32'h0030_0193;
      mem[3] = 32'h0040_0213;
      push(32'h0010_0093, 32'h0, 1'b0);
      push(32'h0020_0113, 32'h4, 1'b0);
      push(32'h0030_0193, 32'h8, 1'b0);
      release_rst();
      wait_drain(20);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      q.delete();
      push(32'h0010_0093, 32'h0, 1'b0);
      push(32'h0020_0113, 32'h4, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_first_valid("refetch_c3");
      wait_drain(20);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
